// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding,
// byte-enable constants and the byte-lane enable helper.
package mem_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    localparam logic [3:0] BE_NONE = 4'h0;
    localparam logic [3:0] BE_WORD = 4'hF;

    // One-hot byte enable for a little-endian byte lane
    function automatic logic [3:0] byte_lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and data memory (slave).
// mem_req is held until the single-cycle mem_ack pulse; mem_rdata is valid with it.
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_store_buffer.sv
// Single-entry posted store buffer for the MEM stage (used with STORE_BUFFER_EN).
// Holds an already-formatted store (aligned address, lane-replicated data, byte
// enables) until the stage drains it through its memory request.
module mem_stage_store_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [3:0]        push_be,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic [3:0]        be
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        be_q, be_d;

    // Next entry: pop empties, push (only offered when empty) fills
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            valid_d = 1'b1;
            addr_d  = push_addr;
            data_d  = push_data;
            be_d    = push_be;
        end
    end

    // Occupancy flag is the only state that needs reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Entry payload, qualified by valid_q
    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    assign valid = valid_q;
    assign addr  = addr_q;
    assign data  = data_q;
    assign be    = be_q;
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data-memory req/ack port,
// stalls upstream until each access completes and registers MEM/WB results.
// Byte loads are sign-extended; word accesses ignore addr[1:0].
// Optional macro STORE_BUFFER_EN adds a 1-entry posted store buffer.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_memRead,
    input  logic        in_memWrite,
    input  logic        in_word,
    input  logic        in_regWrite,
    input  logic        in_flush,
    input  logic [31:0] in_result,
    input  logic [31:0] in_readData2,
    input  logic [4:0]  in_rd,
    output logic        stall,
    mem_stage_if.master mem,
    output logic        wb_regWrite,
    output logic        wb_memToReg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_result,
    output logic [31:0] wb_readData
);
    import mem_stage_pkg::*;

    function automatic logic [31:0] sign_ext_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        b = word[{lane, 3'b000} +: 8];
        return {{24{b[7]}}, b};
    endfunction

    state_e            state_q, state_d;
    logic              drain_q, drain_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              is_load_q, is_load_d;
    logic              reg_write_q, reg_write_d;
    logic              word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       result_q, result_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_result_q, wb_result_d;
    logic [31:0]       wb_read_data_q, wb_read_data_d;
    logic              stall_c;

    logic              memop;
    logic              store_only;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [3:0]        acc_be;
    logic [31:0]       ld_data;

    logic              sb_valid;
    logic [ADDR_W-1:0] sb_addr;
    logic [DATA_W-1:0] sb_wdata;
    logic [3:0]        sb_be;

    assign memop      = (in_memRead | in_memWrite) & ~in_flush;
    assign store_only = in_memWrite & ~in_memRead;
    assign acc_addr   = {in_result[ADDR_W-1:2], 2'b00};
    assign acc_be     = in_word ? BE_WORD : byte_lane_be(in_result[1:0]);
    assign acc_wdata  = in_word ? in_readData2 : {4{in_readData2[7:0]}};
    assign ld_data    = word_q ? mem.mem_rdata : sign_ext_byte(mem.mem_rdata, lane_q);

`ifdef STORE_BUFFER_EN
    localparam bit SB_EN = 1'b1;
    logic sb_push;
    logic sb_pop;

    // Capture a store only in IDLE with the buffer empty; release on drain ack
    assign sb_push = (state_q == ST_IDLE) & ~sb_valid & memop & store_only;
    assign sb_pop  = (state_q == ST_REQ) & drain_q & mem.mem_ack;

    mem_stage_store_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (sb_push),
        .pop       (sb_pop),
        .push_addr (acc_addr),
        .push_data (acc_wdata),
        .push_be   (acc_be),
        .valid     (sb_valid),
        .addr      (sb_addr),
        .data      (sb_wdata),
        .be        (sb_be)
    );
`else
    localparam bit SB_EN = 1'b0;
    assign sb_valid = 1'b0;
    assign sb_addr  = '0;
    assign sb_wdata = '0;
    assign sb_be    = BE_NONE;
`endif

    // Next-state, memory request and MEM/WB result selection
    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_be_d        = mem_be_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        is_load_d       = is_load_q;
        reg_write_d     = reg_write_q;
        word_d          = word_q;
        lane_d          = lane_q;
        rd_d            = rd_q;
        result_d        = result_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_rd_d         = wb_rd_q;
        wb_result_d     = wb_result_q;
        wb_read_data_d  = wb_read_data_q;
        stall_c         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                wb_reg_write_d  = in_regWrite & ~in_flush;
                wb_mem_to_reg_d = 1'b0;
                wb_rd_d         = in_rd;
                wb_result_d     = in_result;
                if (sb_valid) begin
                    // Drain the posted store; a memory op behind it waits
                    state_d     = ST_REQ;
                    drain_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = sb_addr;
                    mem_wdata_d = sb_wdata;
                    mem_be_d    = sb_be;
                    if (memop) begin
                        stall_c        = 1'b1;
                        wb_reg_write_d = 1'b0;
                    end
                end else if (memop) begin
                    wb_reg_write_d = 1'b0;
                    // A posted store is taken by the buffer and retires as a bubble
                    if (!(SB_EN && store_only)) begin
                        stall_c     = 1'b1;
                        state_d     = ST_REQ;
                        drain_d     = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~in_memRead;
                        mem_addr_d  = acc_addr;
                        mem_wdata_d = acc_wdata;
                        mem_be_d    = acc_be;
                        is_load_d   = in_memRead;
                        reg_write_d = in_regWrite;
                        word_d      = in_word;
                        lane_d      = in_result[1:0];
                        rd_d        = in_rd;
                        result_d    = in_result;
                    end
                end
            end
            ST_REQ: begin
                if (drain_q) begin
                    // Non-memory instructions flow past a draining store
                    stall_c         = memop;
                    wb_reg_write_d  = in_regWrite & ~in_flush & ~memop;
                    wb_mem_to_reg_d = 1'b0;
                    wb_rd_d         = in_rd;
                    wb_result_d     = in_result;
                end else begin
                    // In-flight access is older than any flush and always completes
                    stall_c         = ~mem.mem_ack;
                    wb_reg_write_d  = 1'b0;
                    wb_mem_to_reg_d = 1'b0;
                end
                if (mem.mem_ack) begin
                    state_d   = ST_IDLE;
                    drain_d   = 1'b0;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = BE_NONE;
                    if (!drain_q) begin
                        wb_reg_write_d  = is_load_q & reg_write_q;
                        wb_mem_to_reg_d = is_load_q;
                        wb_rd_d         = rd_q;
                        wb_result_d     = result_q;
                        if (is_load_q) begin
                            wb_read_data_d = ld_data;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and MEM/WB registers; async reset abandons any open request at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            drain_q         <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_be_q        <= BE_NONE;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_result_q     <= '0;
            wb_read_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            drain_q         <= drain_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_be_q        <= mem_be_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_q         <= wb_rd_d;
            wb_result_q     <= wb_result_d;
            wb_read_data_q  <= wb_read_data_d;
        end
    end

    // Latched access fields, only consumed while a request is open
    always_ff @(posedge clock) begin
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        is_load_q   <= is_load_d;
        reg_write_q <= reg_write_d;
        word_q      <= word_d;
        lane_q      <= lane_d;
        rd_q        <= rd_d;
        result_q    <= result_d;
    end

    // Stall must act in the same cycle the instruction is presented
    assign stall         = stall_c & ~reset;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;
    assign wb_regWrite   = wb_reg_write_q;
    assign wb_memToReg   = wb_mem_to_reg_q;
    assign wb_rd         = wb_rd_q;
    assign wb_result     = wb_result_q;
    assign wb_readData   = wb_read_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a scoreboard of expected MEM/WB results.
// Build with STORE_BUFFER_EN to exercise the posted store buffer sequence.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_memRead, in_memWrite, in_word, in_regWrite, in_flush;
    logic [31:0] in_result, in_readData2;
    logic [4:0]  in_rd;
    logic        stall;
    logic        wb_regWrite, wb_memToReg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result, wb_readData;

    mem_stage_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_memRead   (in_memRead),
        .in_memWrite  (in_memWrite),
        .in_word      (in_word),
        .in_regWrite  (in_regWrite),
        .in_flush     (in_flush),
        .in_result    (in_result),
        .in_readData2 (in_readData2),
        .in_rd        (in_rd),
        .stall        (stall),
        .mem          (mif),
        .wb_regWrite  (wb_regWrite),
        .wb_memToReg  (wb_memToReg),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .wb_readData  (wb_readData)
    );

    always #5 clock = ~clock;

`ifdef STORE_BUFFER_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef struct {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] read_data;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        in_memRead   = 1'b0;
        in_memWrite  = 1'b0;
        in_word      = 1'b0;
        in_regWrite  = 1'b0;
        in_flush     = 1'b0;
        in_result    = 32'h0;
        in_readData2 = 32'h0;
        in_rd        = 5'd0;
    endtask

    task automatic drive_op(input logic rd_op, input logic wr_op, input logic word, input logic regw,
                            input logic [31:0] res, input logic [31:0] data, input logic [4:0] rd);
        in_memRead   = rd_op;
        in_memWrite  = wr_op;
        in_word      = word;
        in_regWrite  = regw;
        in_flush     = 1'b0;
        in_result    = res;
        in_readData2 = data;
        in_rd        = rd;
    endtask

    task automatic push_exp(input logic rw, input logic mtr, input logic [4:0] rd,
                            input logic [31:0] res, input logic [31:0] rdat);
        exp_t e;
        e.reg_write  = rw;
        e.mem_to_reg = mtr;
        e.rd         = rd;
        e.result     = res;
        e.read_data  = rdat;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expected MEM/WB record and compare against the outputs
    task automatic check_wb(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".wb_regWrite"}, 32'(wb_regWrite), 32'(e.reg_write));
        chk({tag, ".wb_memToReg"}, 32'(wb_memToReg), 32'(e.mem_to_reg));
        if (e.reg_write) begin
            chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(e.rd));
            chk({tag, ".wb_result"}, wb_result, e.result);
        end
        if (e.mem_to_reg) begin
            chk({tag, ".wb_readData"}, wb_readData, e.read_data);
        end
    endtask

    // Play memory for one access already presented on the EX/MEM inputs.
    // Acks after ack_wait non-ack REQ cycles; counts stall cycles throughout.
    task automatic run_access(input string tag, input int ack_wait, input logic [31:0] rdata,
                              input bit flush_in_req, input bit posted,
                              output int stall_cycles, output logic [31:0] req_addr,
                              output logic [31:0] req_wdata, output logic [3:0] req_be,
                              output logic req_we);
        int n;
        stall_cycles = 0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_be       = 4'h0;
        req_we       = 1'b0;
        @(negedge clock);
        if (stall) stall_cycles++;
        @(posedge clock); #1;
        if (posted) begin
            drive_nop();
            check_wb(tag);
        end
        n = 0;
        while (!mif.mem_req && n < 8) begin
            @(negedge clock);
            if (stall) stall_cycles++;
            @(posedge clock); #1;
            n++;
        end
        if (!mif.mem_req) begin
            checks++;
            failures++;
            $error("FAIL %s.mem_req observed=timeout expected=request", tag);
            drive_nop();
            return;
        end
        req_addr  = mif.mem_addr;
        req_wdata = mif.mem_wdata;
        req_be    = mif.mem_be;
        req_we    = mif.mem_we;
        if (flush_in_req) in_flush = 1'b1;
        for (int k = 0; k < ack_wait; k++) begin
            @(negedge clock);
            if (stall) stall_cycles++;
            @(posedge clock); #1;
        end
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rdata;
        @(negedge clock);
        if (stall) stall_cycles++;
        @(posedge clock); #1;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'h0;
        if (!posted) begin
            drive_nop();
            check_wb(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sc;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        we;

        reset         = 1'b1;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'h0;
        drive_nop();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst.stall", 32'(stall), 32'h0);
        chk("rst.mem_req", 32'(mif.mem_req), 32'h0);
        chk("rst.mem_we", 32'(mif.mem_we), 32'h0);
        chk("rst.mem_be", 32'(mif.mem_be), 32'h0);
        chk("rst.wb_regWrite", 32'(wb_regWrite), 32'h0);
        chk("rst.wb_memToReg", 32'(wb_memToReg), 32'h0);
        chk("rst.wb_rd", 32'(wb_rd), 32'h0);
        chk("rst.wb_result", wb_result, 32'h0);
        chk("rst.wb_readData", wb_readData, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Word load, ack on the third REQ cycle
        drive_op(1, 0, 1, 1, 32'h100, 32'h0, 5'd5);
        push_exp(1, 1, 5'd5, 32'h100, 32'hDEADBEEF);
        run_access("ld_word", 2, 32'hDEADBEEF, 0, 0, sc, a, wd, be, we);
        chk("ld_word.stall_cycles", 32'(sc), 32'd3);
        chk("ld_word.mem_addr", a, 32'h100);
        chk("ld_word.mem_be", 32'(be), 32'hF);
        chk("ld_word.mem_we", 32'(we), 32'h0);

        // Minimum latency: ack in first REQ cycle
        drive_op(1, 0, 1, 1, 32'h104, 32'h0, 5'd6);
        push_exp(1, 1, 5'd6, 32'h104, 32'h01234567);
        run_access("ld_fast", 0, 32'h01234567, 0, 0, sc, a, wd, be, we);
        chk("ld_fast.stall_cycles", 32'(sc), 32'd1);

        // Byte load, negative byte in lane 3
        drive_op(1, 0, 0, 1, 32'h103, 32'h0, 5'd7);
        push_exp(1, 1, 5'd7, 32'h103, 32'hFFFFFF80);
        run_access("ld_byte3", 1, 32'h80112233, 0, 0, sc, a, wd, be, we);
        chk("ld_byte3.mem_be", 32'(be), 32'h8);
        chk("ld_byte3.mem_addr", a, 32'h100);

        // Byte load, positive byte in lane 1
        drive_op(1, 0, 0, 1, 32'h1021, 32'h0, 5'd11);
        push_exp(1, 1, 5'd11, 32'h1021, 32'h00000056);
        run_access("ld_byte1", 0, 32'h12345678, 0, 0, sc, a, wd, be, we);
        chk("ld_byte1.mem_be", 32'(be), 32'h2);
        chk("ld_byte1.mem_addr", a, 32'h1020);

        // Misaligned word load is silently aligned
        drive_op(1, 0, 1, 1, 32'h107, 32'h0, 5'd12);
        push_exp(1, 1, 5'd12, 32'h107, 32'hCAFEF00D);
        run_access("ld_misal", 0, 32'hCAFEF00D, 0, 0, sc, a, wd, be, we);
        chk("ld_misal.mem_addr", a, 32'h104);
        chk("ld_misal.mem_be", 32'(be), 32'hF);

        // Byte store: lane-replicated data, one-hot enable, no register write
        drive_op(0, 1, 0, 0, 32'h201, 32'h000000A5, 5'd0);
        push_exp(0, 0, 5'd0, 32'h0, 32'h0);
        run_access("st_byte", 1, 32'h0, 0, POSTED, sc, a, wd, be, we);
        chk("st_byte.mem_wdata", wd, 32'hA5A5A5A5);
        chk("st_byte.mem_be", 32'(be), 32'h2);
        chk("st_byte.mem_we", 32'(we), 32'h1);
        chk("st_byte.mem_addr", a, 32'h200);
        chk("st_byte.stall_cycles", 32'(sc), POSTED ? 32'd0 : 32'd2);

        // Word store
        drive_op(0, 1, 1, 0, 32'h300, 32'h11223344, 5'd0);
        push_exp(0, 0, 5'd0, 32'h0, 32'h0);
        run_access("st_word", 0, 32'h0, 0, POSTED, sc, a, wd, be, we);
        chk("st_word.mem_wdata", wd, 32'h11223344);
        chk("st_word.mem_be", 32'(be), 32'hF);

        // ALU instruction passes straight through
        drive_op(0, 0, 1, 1, 32'h55, 32'h0, 5'd7);
        push_exp(1, 0, 5'd7, 32'h55, 32'h0);
        @(negedge clock);
        chk("alu.stall", 32'(stall), 32'h0);
        chk("alu.mem_req", 32'(mif.mem_req), 32'h0);
        @(posedge clock); #1;
        check_wb("alu");

        // Flushed ALU instruction becomes a bubble
        drive_op(0, 0, 1, 1, 32'h66, 32'h0, 5'd8);
        in_flush = 1'b1;
        push_exp(0, 0, 5'd8, 32'h66, 32'h0);
        @(posedge clock); #1;
        check_wb("alu_flush");

        // Load flushed in IDLE: no request, no stall, no write
        drive_op(1, 0, 1, 1, 32'h100, 32'h0, 5'd3);
        in_flush = 1'b1;
        push_exp(0, 0, 5'd3, 32'h100, 32'h0);
        @(negedge clock);
        chk("ld_flush_idle.stall", 32'(stall), 32'h0);
        chk("ld_flush_idle.mem_req", 32'(mif.mem_req), 32'h0);
        @(posedge clock); #1;
        chk("ld_flush_idle.mem_req_next", 32'(mif.mem_req), 32'h0);
        check_wb("ld_flush_idle");
        drive_nop();

        // Flush raised while in REQ is ignored; the load completes
        drive_op(1, 0, 1, 1, 32'h180, 32'h0, 5'd4);
        push_exp(1, 1, 5'd4, 32'h180, 32'h0BADF00D);
        run_access("ld_flush_req", 1, 32'h0BADF00D, 1, 0, sc, a, wd, be, we);

        // Reset in REQ drops request and stall immediately
        drive_op(1, 0, 1, 1, 32'h140, 32'h0, 5'd2);
        @(posedge clock); #1;
        chk("rst_req.mem_req_before", 32'(mif.mem_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_req.mem_req", 32'(mif.mem_req), 32'h0);
        chk("rst_req.stall", 32'(stall), 32'h0);
        drive_nop();
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_req.wb_regWrite", 32'(wb_regWrite), 32'h0);
        drive_op(1, 0, 1, 1, 32'h144, 32'h0, 5'd2);
        push_exp(1, 1, 5'd2, 32'h144, 32'h5A5A5A5A);
        run_access("ld_after_rst", 1, 32'h5A5A5A5A, 0, 0, sc, a, wd, be, we);
        chk("ld_after_rst.stall_cycles", 32'(sc), 32'd2);
        chk("ld_after_rst.mem_addr", a, 32'h144);

`ifdef STORE_BUFFER_EN
        // Posted store followed by a load: load waits for the drain, then issues
        drive_op(0, 1, 1, 0, 32'h400, 32'h12345678, 5'd0);
        push_exp(0, 0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        chk("sb.store_stall", 32'(stall), 32'h0);
        @(posedge clock); #1;
        check_wb("sb.store");
        drive_op(1, 0, 1, 1, 32'h500, 32'h0, 5'd9);
        @(negedge clock);
        chk("sb.load_stall_drain", 32'(stall), 32'h1);
        @(posedge clock); #1;
        chk("sb.drain_req", 32'(mif.mem_req), 32'h1);
        chk("sb.drain_we", 32'(mif.mem_we), 32'h1);
        chk("sb.drain_addr", mif.mem_addr, 32'h400);
        chk("sb.drain_wdata", mif.mem_wdata, 32'h12345678);
        mif.mem_ack = 1'b1;
        @(negedge clock);
        chk("sb.load_stall_ack", 32'(stall), 32'h1);
        @(posedge clock); #1;
        mif.mem_ack = 1'b0;
        chk("sb.req_dropped", 32'(mif.mem_req), 32'h0);
        push_exp(1, 1, 5'd9, 32'h500, 32'h00000077);
        run_access("sb.load", 0, 32'h00000077, 0, 0, sc, a, wd, be, we);
        chk("sb.load_addr", a, 32'h500);
        chk("sb.load_we", 32'(we), 32'h0);
        chk("sb.load_stall_cycles", 32'(sc), 32'd1);
`endif

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
